// File: rtl/hex_display_ctrl.sv
// Signed integer to four 7-seg digit codes (HEX3..HEX0) using a serial double-dabble engine.
// Optional build macro HEXCTRL_LZB_EN: blank leading positions instead of showing zeros.
module hex_display_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [3:0]       dig0,
    output logic [3:0]       dig1,
    output logic [3:0]       dig2,
    output logic [3:0]       dig3,
    output logic             out_valid,
    output logic             ovf
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ABS    = 2'd1;
    localparam logic [1:0] S_SHIFT  = 2'd2;
    localparam logic [1:0] S_FORMAT = 2'd3;

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] LIM_POS = WIDTH'(32'd9999);
    localparam logic [WIDTH-1:0] LIM_NEG = WIDTH'(32'd999);

    localparam logic [3:0] CODE_DASH = 4'hA;
`ifdef HEXCTRL_LZB_EN
    localparam logic [3:0] CODE_FILL = 4'hF;
`else
    localparam logic [3:0] CODE_FILL = 4'h0;
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             neg_q, neg_d;
    logic             oflag_q, oflag_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       dig_q [4];
    logic [3:0]       dig_d [4];
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic             neg_s;
    logic [WIDTH-1:0] mag_s;
    logic             range_ovf_s;
    logic [15:0]      bcd_adj_s;
    logic [2:0]       sig_n_s;
    logic [3:0]       fmt_s [4];

    // Magnitude and range check of the latched value; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        neg_s       = data_q[WIDTH-1];
        mag_s       = data_q;
        if (neg_s) begin
            mag_s = ~data_q + WIDTH'(1);
        end else begin
            mag_s = data_q;
        end
        range_ovf_s = (mag_s > LIM_POS) || (neg_s && (mag_s > LIM_NEG));
    end

    // Add-3 correction applied to every BCD nibble before the shift.
    always_comb begin
        bcd_adj_s = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj_s[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
    end

    // Display formatting: digits below n, minus at n when negative, fill above.
    always_comb begin
        sig_n_s = 3'd1;
        if (bcd_q[15:12] != 4'h0) begin
            sig_n_s = 3'd4;
        end else if (bcd_q[11:8] != 4'h0) begin
            sig_n_s = 3'd3;
        end else if (bcd_q[7:4] != 4'h0) begin
            sig_n_s = 3'd2;
        end else begin
            sig_n_s = 3'd1;
        end
        for (int i = 0; i < 4; i++) begin
            fmt_s[i] = CODE_FILL;
            if (oflag_q) begin
                fmt_s[i] = CODE_DASH;
            end else if (3'(i) < sig_n_s) begin
                fmt_s[i] = bcd_q[4*i +: 4];
            end else if (neg_q && (3'(i) == sig_n_s)) begin
                fmt_s[i] = CODE_DASH;
            end else begin
                fmt_s[i] = CODE_FILL;
            end
        end
    end

    // Next-state logic for the conversion FSM and datapath.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        neg_d       = neg_q;
        oflag_d     = oflag_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dig_d[i] = dig_q[i];
        end
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    state_d = S_ABS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ABS: begin
                neg_d   = neg_s;
                data_d  = mag_s;
                oflag_d = range_ovf_s;
                bcd_d   = 16'h0000;
                cnt_d   = CNT_W'(WIDTH - 1);
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // Top BCD bit is dropped; anything that large was already flagged in ABS.
                bcd_d  = {bcd_adj_s[14:0], data_q[WIDTH-1]};
                data_d = {data_q[WIDTH-2:0], 1'b0};
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = S_FORMAT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FORMAT: begin
                for (int i = 0; i < 4; i++) begin
                    dig_d[i] = fmt_s[i];
                end
                ovf_d       = oflag_q;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            data_q      <= {WIDTH{1'b0}};
            neg_q       <= 1'b0;
            oflag_q     <= 1'b0;
            bcd_q       <= 16'h0000;
            cnt_q       <= {CNT_W{1'b0}};
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                dig_q[i] <= 4'hF;
            end
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            neg_q       <= neg_d;
            oflag_q     <= oflag_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < 4; i++) begin
                dig_q[i] <= dig_d[i];
            end
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign dig0      = dig_q[0];
    assign dig1      = dig_q[1];
    assign dig2      = dig_q[2];
    assign dig3      = dig_q[3];
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Sequential controller that turns a signed integer into four 7-seg digit codes for the HEX3..HEX0 display path.
- Uses a valid/ready input handshake and a multi-cycle double-dabble (shift-add-3) engine, replacing per-digit combinational divide/modulo.
- Handles sign placement, range overflow and leading-zero formatting.
- Outputs drive four CharToHex-style decoders: dig0 is the least-significant digit and feeds the rightmost display.

Parameters:
- WIDTH, 16, bit width of signed input in_data; legal range 15..32.

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  in_data is valid
- in_data  in  WIDTH  signed two's-complement value to display
- in_ready  out  1  controller can accept a value; equals (state==IDLE)
- dig0  out  4  digit code, ones position
- dig1  out  4  digit code, tens position
- dig2  out  4  digit code, hundreds position
- dig3  out  4  digit code, thousands position
- out_valid  out  1  one-cycle pulse when dig0..dig3 have just updated
- ovf  out  1  registered; 1 if the last converted value was out of range

Behaviour:
- Digit codes: 0-9 are decimal digits, 4'hA is minus/dash, 4'hF is blank. No other codes are ever driven.
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; dig0..dig3=4'hF; out_valid=0; ovf=0; internal registers cleared.
  - Reset in any state aborts the conversion; no out_valid is produced.
- FSM states: IDLE, ABS, SHIFT, FORMAT.
  - IDLE: at an edge with in_valid=1, latch in_data and go to ABS. in_ready=1 only in IDLE.
  - ABS (1 cycle): compute neg=in_data[WIDTH-1] and mag=|in_data| as a WIDTH-bit unsigned value, so -2^(WIDTH-1) is represented correctly.
    - Set the ovf flag if mag>9999, or if neg and mag>999.
    - Clear the 16-bit BCD register and set bit counter=WIDTH-1.
  - SHIFT (exactly WIDTH cycles): each cycle, add 3 to every BCD nibble >=5, then shift {bcd,mag} left by 1.
    - The counter decrements each cycle; leave SHIFT when it reaches 0.
    - Only the 4 low BCD nibbles are kept. Truncation is harmless because out-of-range values are already flagged.
  - FORMAT (1 cycle): write dig0..dig3 and ovf, pulse out_valid=1 in the following cycle, then return to IDLE.
- Latency: the accept edge is k. dig*/ovf update and out_valid goes high at edge k+WIDTH+2 (18 for WIDTH=16), regardless of value or overflow.
- Formatting:
  - ovf=1: all four digits = 4'hA ("----").
  - Otherwise, with n = number of significant digits (1 for value 0): positions below n show BCD digits.
  - If neg: position n shows 4'hA. Since neg implies mag<=999, n<=3.
  - Remaining higher positions are set per the optional feature.
- Hold: dig*/ovf hold their values between out_valid pulses.
- Back-to-back: in_valid held high is re-accepted in the cycle after out_valid (state is IDLE), so throughput is one value per WIDTH+3 cycles.
- in_data changes while not IDLE are ignored.

Optional Feature:
- Macro: HEXCTRL_LZB_EN.
- Defined: leading positions above the number (and above the minus) show 4'hF blank, e.g. 42 -> F,F,4,2.
- Not defined: those positions show digit 0, e.g. 42 -> 0,0,4,2 and -7 -> 0,0,A,7; the minus still sits at position n.
- Overflow and reset values are identical in both builds.

Test Plan:
- Build WIDTH=16 with HEXCTRL_LZB_EN defined. All digit sequences below are listed as dig3,dig2,dig1,dig0.
- Reset then idle: dig3..dig0=F,F,F,F; out_valid=0; in_ready=1. Then accept 0 -> 18 cycles later F,F,F,0, ovf=0, out_valid one cycle only.
- Positive values:
  - 42 -> F,F,4,2.
  - 9999 -> 9,9,9,9.
  - 10000 -> A,A,A,A with ovf=1.
  - 32767 -> A,A,A,A with ovf=1.
- Negative values:
  - -7 -> F,F,A,7.
  - -999 -> A,9,9,9.
  - -1000 -> A,A,A,A with ovf=1.
  - -32768 -> A,A,A,A with ovf=1.
- Handshake: hold in_valid=1 with 123 then 456 -> 123 accepted; in_ready=0 for 18 cycles; 456 accepted in the cycle after out_valid; second out_valid exactly 19 cycles after the first.
- Reset mid-SHIFT (5 cycles after accepting 1234) -> no out_valid; digits F,F,F,F; next value 8 converts normally to F,F,F,8.
- Build without HEXCTRL_LZB_EN:
  - 42 -> 0,0,4,2.
  - -7 -> 0,0,A,7.
  - 0 -> 0,0,0,0.
  - reset state F,F,F,F.
